// File: rtl/avm_sram_bus_adapter.sv
// avm_sram_bus_adapter
//   Bridges a 32-bit Avalon-MM slave port onto a 16-bit SRAM controller.
//   Each 32-bit access becomes two 16-bit halves, low half first. The
//   sequence is IDLE -> LO -> HI -> DONE.
//
//   Timing
//     A request seen in IDLE at cycle 0 completes in cycle 3, when
//     s_waitrequest drops to 0. Reads always take this path.
//     With SKIP_EMPTY_HALF=1, a write skips any half whose byte-enable
//     pair is 2'b00.
//
//   Downstream controller
//     Returns read data one cycle after m_read and has no waitrequest.
//
// Parameters
//   SKIP_EMPTY_HALF : 1 = do not issue write halves whose byteenable pair is 2'b00
//
// Ports
//   clk, reset                 : clock; synchronous active-high reset
//   s_address[16:0]            : upstream 32-bit word address
//   s_byteenable[3:0]          : upstream byte lanes
//   s_read, s_write            : upstream request strobes (read wins if both)
//   s_writedata[31:0]          : upstream write data
//   s_readdata[31:0]           : upstream read data (zero outside a read completion)
//   s_waitrequest              : low only in the completion cycle
//   m_address[17:0]            : SRAM halfword address
//   m_byteenable[1:0]          : SRAM byte lanes
//   m_read, m_write            : SRAM strobes (one cycle per half)
//   m_writedata[15:0]          : SRAM write data
//   m_readdata[15:0]           : SRAM read data (one cycle after m_read)
module avm_sram_bus_adapter #(
  parameter bit SKIP_EMPTY_HALF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] s_address,
  input  logic [3:0]  s_byteenable,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        s_waitrequest,
  output logic [17:0] m_address,
  output logic [1:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nx;

  // Request fields captured on acceptance. The bus master may change its
  // inputs afterwards without disturbing the transfer in flight.
  logic [16:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic        rd_q;

  // Low-half read result. It is sampled in HI, one cycle after the LO strobe.
  logic [15:0] hold_q;

  logic        req;
  logic        req_rd;
  logic        lo_empty;
  logic        hi_empty;
  logic        hi_empty_q;

  assign req      = s_read | s_write;
  assign req_rd   = s_read;           // read takes priority when both are high
  assign lo_empty = (s_byteenable[1:0] == 2'b00);
  assign hi_empty = (s_byteenable[3:2] == 2'b00);
  assign hi_empty_q = (be_q[3:2] == 2'b00);

  // State register and request capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      be_q   <= '0;
      wd_q   <= '0;
      rd_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        addr_q <= s_address;
        be_q   <= s_byteenable;
        wd_q   <= s_writedata;
        rd_q   <= req_rd;
      end
      if (state == HI && rd_q)
        hold_q <= m_readdata;
    end
  end

  // Next-state logic and outputs
  always_comb begin
    state_nx      = state;
    s_waitrequest = 1'b1;
    s_readdata    = 32'h0;
    m_address     = {addr_q, 1'b0};
    m_byteenable  = 2'b00;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = 16'h0;

    unique case (state)
      IDLE: begin
        if (req) begin
          // Writes may bypass empty halves. Reads always do both.
          if (!req_rd && SKIP_EMPTY_HALF && lo_empty)
            state_nx = hi_empty ? DONE : HI;
          else
            state_nx = LO;
        end
      end

      LO: begin
        m_address    = {addr_q, 1'b0};
        m_byteenable = rd_q ? 2'b11 : be_q[1:0];
        m_read       = rd_q;
        m_write      = !rd_q;
        m_writedata  = wd_q[15:0];
        if (!rd_q && SKIP_EMPTY_HALF && hi_empty_q)
          state_nx = DONE;
        else
          state_nx = HI;
      end

      HI: begin
        m_address    = {addr_q, 1'b1};
        m_byteenable = rd_q ? 2'b11 : be_q[3:2];
        m_read       = rd_q;
        m_write      = !rd_q;
        m_writedata  = wd_q[31:16];
        state_nx     = DONE;
      end

      DONE: begin
        s_waitrequest = 1'b0;
        // m_readdata now carries the high-half result of the HI strobe.
        if (rd_q)
          s_readdata = {m_readdata, hold_q};
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/avm_sram_bus_adapter.md
AVM_SRAM_BUS_ADAPTER -- requirements
Module: avm_sram_bus_adapter

Interface
REQ-001 The block SHALL have parameter SKIP_EMPTY_HALF, default 1: when 1, a write half whose byteenable pair is 2'b00 is not issued downstream.
REQ-002 The block SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-004 The block SHALL have port s_address, input, 17: 32-bit word address, upstream Avalon MM slave.
REQ-005 The block SHALL have port s_byteenable, input, 4: byte lanes of s_writedata.
REQ-006 The block SHALL have ports s_read and s_write, input, 1 each: request strobes, mutually exclusive, held by master until s_waitrequest low.
REQ-007 The block SHALL have port s_writedata, input, 32: write data.
REQ-008 The block SHALL have port s_readdata, output, 32: read data, valid when s_waitrequest=0 for a read.
REQ-009 The block SHALL have port s_waitrequest, output, 1: transfer completes in the cycle this is 0 with a request present.
REQ-010 The block SHALL have ports m_address (output, 18), m_byteenable (output, 2), m_read (output, 1), m_write (output, 1), m_writedata (output, 16), m_readdata (input, 16): downstream 16-bit SRAM controller port; controller returns read data one cycle after m_read, with no waitrequest.

Function
REQ-011 The block SHALL split each 32-bit access into a low half (m_address={addr,1'b0}, m_byteenable=be[1:0], m_writedata=wd[15:0]) and a high half ({addr,1'b1}, be[3:2], wd[31:16]), low first.
REQ-012 The block SHALL implement states IDLE, LO, HI, DONE.
REQ-013 IDLE: s_waitrequest=1, m_read=m_write=0; on s_read or s_write, latch address, byteenable, writedata and direction, then go to LO.
REQ-014 LO: issue low half (m_read or m_write=1 for exactly this cycle); next state HI.
REQ-015 HI: issue high half; on a read, capture m_readdata (low-half result) into a 16-bit holding register; next state DONE.
REQ-016 DONE: s_waitrequest=0; on a read, s_readdata={m_readdata, holding register}; next state IDLE.
REQ-017 Read latency SHALL be fixed: request seen in IDLE at cycle 0, s_waitrequest=0 in cycle 3.
REQ-018 With SKIP_EMPTY_HALF=1, a write SHALL skip LO when be[1:0]=0 (IDLE->HI) and skip HI when be[3:2]=0 (LO->DONE); be=4'b0000 goes IDLE->DONE with no downstream strobe.
REQ-019 Reads SHALL always issue both halves with m_byteenable=2'b11 regardless of s_byteenable.
REQ-020 With SKIP_EMPTY_HALF=0 every write SHALL issue both halves, each with its own byteenable pair, including 2'b00.
REQ-021 m_read and m_write SHALL never be asserted together, and neither SHALL be asserted in IDLE or DONE.
REQ-022 Requests present while not in IDLE SHALL not be re-latched; s_address, s_byteenable and s_writedata changes after acceptance SHALL not affect the transfer.
REQ-023 If s_read and s_write are both high in IDLE, the block SHALL treat the request as a read.
REQ-024 s_readdata outside DONE-read SHALL be 32'h0.
REQ-025 Back-to-back requests SHALL each take the full sequence; the block accepts a new request in the IDLE cycle after DONE.

Reset
REQ-026 Reset SHALL force state IDLE, s_waitrequest=1, m_read=0, m_write=0, holding register=0 and s_readdata=0 at the next clock edge.
REQ-027 Reset asserted in LO, HI or DONE SHALL abandon the transfer with no completion cycle; a half already issued is not undone.

Verification
REQ-028 Read, s_address=17'h00010, SRAM holds 0x1234 at 18'h00020 and 0xABCD at 18'h00021 -> m_read at 0x20 then 0x21, cycle 3 s_readdata=32'hABCD1234, s_waitrequest=0.
REQ-029 Write 32'hDEADBEEF, be=4'hF, address 17'h1FFFF -> m_write 0xBEEF at 18'h3FFFE be 2'b11, then 0xDEAD at 18'h3FFFF, completion in cycle 3.
REQ-030 Write be=4'b1100 (SKIP_EMPTY_HALF=1) -> single m_write at odd address with data wd[31:16], completion in cycle 2; be=4'b0000 -> no m_write, completion in cycle 1.
REQ-031 Write be=4'b0011 with SKIP_EMPTY_HALF=0 -> two m_write cycles, second with m_byteenable=2'b00.
REQ-032 Reset asserted in HI of a read -> no s_waitrequest=0 cycle, m_read=0 next cycle, following read returns correct data.
REQ-033 Read immediately followed by write, s_read/s_write with s_read=s_write=1 -> first treated as read, write accepted in IDLE after DONE; no overlapping strobes.
